// File: rtl/ddr_resp_pkg.sv
// ddr_resp_pkg: shared line/beat geometry, command codes, FSM encoding and
// beat-address helper for the DDR line responder.
package ddr_resp_pkg;
   localparam int BEATS  = 4;
   localparam int BEAT_W = 128;
   localparam int LINE_W = BEATS * BEAT_W;
   localparam int ADDR_W = 32;
   localparam int BIDX_W = $clog2(BEATS);
   localparam int LOFF_W = $clog2(LINE_W / 8);
   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RCMD, S_RDATA, S_ACK} state_t;
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-LOFF_W-1:0] line,
                                                   input logic [BIDX_W-1:0] k);
      return {line, k, {(LOFF_W-BIDX_W){1'b0}}};
   endfunction
endpackage

// File: rtl/ddr_line_gather.sv
// ddr_line_gather: collects BEATS read beats, in arrival order, into one cache line.
// done is combinational so the owner can leave its wait state on the last beat itself.
module ddr_line_gather
   import ddr_resp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              vld,
   input  logic [BEAT_W-1:0] data,
   output logic [LINE_W-1:0] line,
   output logic              done
);
   logic [LINE_W-1:0] line_q, line_d;
   logic [BIDX_W:0]   rcv_q, rcv_d;
   logic              take;
   always_comb begin
      take   = en && vld && rcv_q != (BIDX_W+1)'(BEATS);
      line_d = line_q;
      if (take) line_d[rcv_q[BIDX_W-1:0]*BEAT_W +: BEAT_W] = data;
      rcv_d  = clr ? '0 : rcv_q + {{BIDX_W{1'b0}}, take};
   end
   assign done = rcv_d == (BIDX_W+1)'(BEATS);
   assign line = line_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         line_q <= '0;
         rcv_q  <= '0;
      end else begin
         line_q <= line_d;
         rcv_q  <= rcv_d;
      end
endmodule

// File: rtl/ddr_line_responder.sv
// ddr_line_responder: Wishbone classic line slave that splits each 512-bit line
// into native-interface beats and reassembles read data before acking.
module ddr_line_responder
   import ddr_resp_pkg::*;
(
   input  logic                clkDDR,
   input  logic                rstn,
   input  logic [ADDR_W-1:0]   addrDDR,
   input  logic [LINE_W-1:0]   doutDDR,
   output logic [LINE_W-1:0]   dinDDR,
   input  logic [LINE_W/8-1:0] dmDDR,
   input  logic                cycDDR,
   input  logic                stbDDR,
   input  logic                weDDR,
   output logic                ackDDR,
   output logic [ADDR_W-1:0]   memAddr,
   output logic [2:0]          memCmd,
   output logic                memEn,
   input  logic                memRdy,
   output logic [BEAT_W-1:0]   memWdfData,
   output logic [BEAT_W/8-1:0] memWdfMask,
   output logic                memWdfWren,
   output logic                memWdfEnd,
   input  logic                memWdfRdy,
   input  logic [BEAT_W-1:0]   memRdData,
   input  logic                memRdDataValid,
   output logic                busy
);
   state_t                     state_q, state_d;
   logic [BIDX_W-1:0]          iss_q, iss_d;
   logic [ADDR_W-LOFF_W-1:0]   line_q, line_d;
   logic [LINE_W-1:0]          wdat_q, wdat_d;
   logic [LINE_W/8-1:0]        dm_q, dm_d;
   logic                       we_q, we_d;
   logic [LINE_W-1:0]          din_q, din_d;
   logic [LINE_W-1:0]          g_line;
   logic                       g_clr, g_en, g_done, wr, rc, last;

   ddr_line_gather u_gather (
      .clk   (clkDDR),
      .rst_n (rstn),
      .clr   (g_clr),
      .en    (g_en),
      .vld   (memRdDataValid),
      .data  (memRdData),
      .line  (g_line),
      .done  (g_done)
   );

   assign wr   = state_q == S_WRITE;
   assign rc   = state_q == S_RCMD;
   assign last = iss_q == BIDX_W'(BEATS-1);
   assign g_en = rc || state_q == S_RDATA;

   always_comb begin
      state_d = state_q;
      iss_d   = iss_q;
      line_d  = line_q;
      wdat_d  = wdat_q;
      dm_d    = dm_q;
      we_d    = we_q;
      din_d   = din_q;
      g_clr   = 1'b0;
      case (state_q)
         S_IDLE:
            if (cycDDR && stbDDR) begin
               line_d  = addrDDR[ADDR_W-1:LOFF_W];
               wdat_d  = doutDDR;
               dm_d    = dmDDR;
               we_d    = weDDR;
               iss_d   = '0;
               g_clr   = 1'b1;
               state_d = weDDR ? S_WRITE : S_RCMD;
            end
         // A write beat needs the command and the data FIFO in the same cycle.
         S_WRITE:
            if (memRdy && memWdfRdy) begin
               iss_d   = iss_q + 1'b1;
               state_d = last ? S_ACK : S_WRITE;
            end
         S_RCMD:
            if (memRdy) begin
               iss_d   = iss_q + 1'b1;
               state_d = last ? S_RDATA : S_RCMD;
            end
         S_RDATA:
            state_d = g_done ? S_ACK : S_RDATA;
         default: begin
            state_d = S_IDLE;
            din_d   = we_q ? din_q : g_line;
         end
      endcase
   end

   always_ff @(posedge clkDDR or negedge rstn)
      if (!rstn) begin
         state_q <= S_IDLE;
         iss_q   <= '0;
         line_q  <= '0;
         wdat_q  <= '0;
         dm_q    <= '0;
         we_q    <= 1'b0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         line_q  <= line_d;
         wdat_q  <= wdat_d;
         dm_q    <= dm_d;
         we_q    <= we_d;
         din_q   <= din_d;
      end

   assign memEn      = wr || rc;
   assign memCmd     = rc ? CMD_READ : CMD_WRITE;
   assign memAddr    = memEn ? beat_addr(line_q, iss_q) : '0;
   assign memWdfWren = wr;
   assign memWdfEnd  = wr;
   assign memWdfData = wr ? wdat_q[iss_q*BEAT_W +: BEAT_W] : '0;
   assign memWdfMask = wr ? ~dm_q[iss_q*(BEAT_W/8) +: BEAT_W/8] : '0;
   assign ackDDR     = state_q == S_ACK && cycDDR;
   assign busy       = state_q != S_IDLE;
   // The gathered line is shown directly in ACK; it is copied to din_q on leaving.
   assign dinDDR     = (state_q == S_ACK && !we_q) ? g_line : din_q;
endmodule

// File: doc/ddr_line_responder.md
Name: ddr_line_responder

Overview:
- Wishbone classic slave on the DDR side of the cache subsystem; it is the responder for the 512-bit cache-line master port shared by ICache and DCache.
- Accepts one full-line read or masked write per transaction.
- Splits each line into BEATS narrow beats on a MIG-style native memory interface, then reassembles read data and acks the master.

Parameters:
- BEATS, 4, memory beats per cache line
- BEAT_W, 128, memory data width in bits; line width = BEATS*BEAT_W = 512
- ADDR_W, 32, byte address width

Ports:
- clkDDR  in  1  DDR-domain clock; all logic on its rising edge
- rstn  in  1  asynchronous active-low reset
- addrDDR  in  32  wishbone byte address; bits [5:0] ignored (line-aligned)
- doutDDR  in  512  write line from master
- dinDDR  out  512  read line to master
- dmDDR  in  64  byte enables, bit i=1 writes byte i
- cycDDR  in  1  wishbone cycle
- stbDDR  in  1  wishbone strobe
- weDDR  in  1  1=write, 0=read
- ackDDR  out  1  one-cycle transfer acknowledge
- memAddr  out  32  beat byte address
- memCmd  out  3  3'b000 write, 3'b001 read
- memEn  out  1  command valid
- memRdy  in  1  command accepted when memEn&memRdy
- memWdfData  out  128  write beat data
- memWdfMask  out  16  write beat mask, bit=1 means byte NOT written
- memWdfWren  out  1  write data valid
- memWdfEnd  out  1  last word of burst; equals memWdfWren
- memWdfRdy  in  1  write FIFO ready
- memRdData  in  128  read beat data
- memRdDataValid  in  1  read beat valid; beats return in issue order
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; beat counters 0; ackDDR, memEn, memWdfWren, memWdfEnd, busy = 0; memAddr, memCmd, memWdfData, memWdfMask, dinDDR = 0.
- Reset mid-operation aborts the transaction with no ack; pending memory read beats arriving after reset release are ignored.
- States: IDLE, WRITE, RCMD, RDATA, ACK.
- IDLE: on cycDDR&stbDDR, latch addrDDR[31:6], doutDDR, dmDDR, weDDR; go to WRITE if we, else RCMD. Clear issue counter and receive counter. busy rises the next cycle.
- Beat k occupies line bits [128k+127:128k] and mask bits [16k+15:16k]. Its address is {line[31:6], k[1:0], 4'b0}, so beat 0 is the lowest address.
- WRITE:
  - memEn=memWdfWren=memWdfEnd=1, memCmd=000, memWdfMask=~dm slice.
  - A beat advances only in a cycle where memRdy&memWdfRdy; neither handshake completes alone.
  - All BEATS beats are issued even when the dm slice is zero.
  - After beat BEATS-1 is accepted, go to ACK.
- RCMD:
  - memEn=1, memCmd=001; the issue counter advances on memRdy.
  - After beat BEATS-1 is accepted, go to RDATA.
- Read data capture (valid in RCMD and RDATA):
  - On each memRdDataValid, store memRdData in slot rcv and increment rcv.
  - Data arriving during RCMD, including in the same cycle as a command accept, must be captured.
  - When rcv reaches BEATS, go to ACK. Ack is asserted the cycle after the last valid beat.
  - memRdDataValid in IDLE, WRITE or ACK is ignored.
- ACK:
  - ackDDR=1 for exactly one cycle, only if cycDDR is still high; then IDLE.
  - dinDDR holds the assembled line from ACK until the next read reaches ACK.
- cycDDR dropped mid-operation: memory beats already started still complete; ack is suppressed; return to IDLE.
- A new request is sampled only in IDLE. The master deasserts stb within one cycle of ack.
- Minimum write latency: BEATS+1 cycles from request to ack.

Decomposition:
- Shared package ddr_resp_pkg holds:
  - state enum
  - BEATS, BEAT_W, LINE_W
  - CMD_WRITE=3'b000, CMD_READ=3'b001
  - beat-address helper function
- One sub-module: ddr_line_gather. It is the read-beat assembler: BEATS x BEAT_W register slots, rcv counter, done flag, clear input.

Test Plan:
- Read at addrDDR=32'h0000_1047; memRdy=1; data D0..D3 with latency 3 -> memAddr 0x1040/0x1050/0x1060/0x1070; dinDDR={D3,D2,D1,D0}; single ackDDR one cycle after D3.
- Write with dmDDR=64'hFFFF_0000_0000_FFFF -> memWdfMask beat0=16'h0000, beat1=16'hFFFF, beat2=16'hFFFF, beat3=16'h0000; ack 5 cycles after request with no backpressure.
- Write where memRdy and memWdfRdy toggle out of phase for 10 cycles -> no beat advance until both are high; beats stay in order; exactly 4 accepts.
- Read with memRdDataValid one cycle after each command accept (overlapping RCMD) -> all 4 beats captured in order; no lost beat.
- cycDDR dropped after write beat 1 -> beats 2 and 3 still issued; ackDDR stays 0; busy falls; next read completes normally.
- rstn pulsed low after 2 read beats received -> all outputs 0 immediately; after release, a new read to 0x2000 returns the correct line.
